// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus among RS/ALU, load buffer, branch.
// Optional build macro CDB_ARB_FIXED_PRIO_EN selects fixed priority.
module cdb_arbiter #(
    parameter int NREQ       = 3,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic [NREQ-1:0]            req_valid_in,
    input  logic [NREQ*ROB_WIDTH-1:0]  req_tag_in,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NREQ-1:0]            req_ready_out,
    output logic                       cdb_en_out,
    output logic [ROB_WIDTH-1:0]       cdb_tag_out,
    output logic [DATA_WIDTH-1:0]      cdb_data_out,
    output logic [1:0]                 cdb_src_out
);

    logic [NREQ-1:0]       slot_valid;
    logic [ROB_WIDTH-1:0]  slot_tag  [NREQ];
    logic [DATA_WIDTH-1:0] slot_data [NREQ];
    logic [NREQ-1:0]       grant;
    logic [1:0]            gidx;
    logic [1:0]            idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
    logic [1:0]            ptr;
    logic [2:0]            sum;
`endif

    // Pick the first valid slot, starting at ptr (or at 0 for fixed prio).
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
        sum   = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
            idx = 2'(k);
`else
            sum = {1'b0, ptr} + 3'(k);
            if (sum >= 3'(NREQ)) begin
                sum = sum - 3'(NREQ);
            end
            idx = sum[1:0];
`endif
            if (slot_valid[idx] && (grant == '0)) begin
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    // A slot accepts when empty or being drained on this same edge.
    always_comb begin
        req_ready_out = '0;
        if (!rst_in) begin
            req_ready_out = {NREQ{rdy_in & ~flush_in}}
                          & (~slot_valid | grant);
        end
    end

    // Slot fill/drain, broadcast register and pointer update.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_valid   <= '0;
            cdb_en_out   <= 1'b0;
            cdb_tag_out  <= '0;
            cdb_data_out <= '0;
            cdb_src_out  <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
            ptr          <= '0;
`endif
            for (int i = 0; i < NREQ; i++) begin
                slot_tag[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                slot_valid <= '0;
                cdb_en_out <= 1'b0;
`ifndef CDB_ARB_FIXED_PRIO_EN
                ptr        <= '0;
`endif
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant[i]) begin
                        slot_valid[i] <= 1'b0;
                    end
                    if (req_valid_in[i] && req_ready_out[i]
                        && (req_tag_in[i*ROB_WIDTH +: ROB_WIDTH] != '0)) begin
                        slot_valid[i] <= 1'b1;
                        slot_tag[i]   <= req_tag_in[i*ROB_WIDTH +: ROB_WIDTH];
                        slot_data[i]  <= req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (grant != '0) begin
                    cdb_en_out   <= 1'b1;
                    cdb_tag_out  <= slot_tag[gidx];
                    cdb_data_out <= slot_data[gidx];
                    cdb_src_out  <= gidx;
`ifndef CDB_ARB_FIXED_PRIO_EN
                    ptr <= (gidx == 2'(NREQ-1)) ? 2'd0 : gidx + 2'd1;
`endif
                end else begin
                    cdb_en_out <= 1'b0;
                end
            end
        end
    end

endmodule
